// File: rtl/seg7_mux_capture.sv
// seg7_mux_capture: qualifies a multiplexed 7-segment bus by stability, decodes each
// digit back to a 5-bit code and assembles 4-digit frames onto a valid/ready handshake.
`default_nettype none

module seg7_mux_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  seg_in,
  input  logic [1:0]  sel_in,
  input  logic        err_clr,
  input  logic        frame_ready,
  output logic [4:0]  dig0,
  output logic [4:0]  dig1,
  output logic [4:0]  dig2,
  output logic [4:0]  dig3,
  output logic [19:0] frame_data,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        overflow
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_BAD   = 5'd31;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OFFER   = 1'b1
  } state_t;

  state_t      state_q, state_nxt;
  logic [8:0]  sample, last_q;
  logic [7:0]  cnt_q, cnt_nxt;
  logic        same, commit;
  logic [4:0]  code;
  logic [4:0]  dig_q   [4];
  logic [4:0]  dig_nxt [4];
  logic [3:0]  seen_q, seen_set;
  logic        frame_done, load, drop;
  logic        unused_bits;

  assign unused_bits = ^seg_in[1:0];
  assign sample      = {seg_in[8:2], sel_in};
  assign same        = (sample == last_q);

  // Saturating run-length counter; a commit fires only on the edge that reaches STABLE.
  always_comb begin
    cnt_nxt = 8'd1;
    if (same) cnt_nxt = (cnt_q < STABLE) ? cnt_q + 8'd1 : cnt_q;
  end
  assign commit = (cnt_nxt == STABLE) && (!same || (cnt_q < STABLE));

  always_comb begin
    case (seg_in[8:2])
      7'b1111110: code = 5'd0;
      7'b0110000: code = 5'd1;
      7'b1101101: code = 5'd2;
      7'b1111001: code = 5'd3;
      7'b0110011: code = 5'd4;
      7'b1011011: code = 5'd5;
      7'b1011111: code = 5'd6;
      7'b1110000: code = 5'd7;
      7'b1111111: code = 5'd8;
      7'b1111011: code = 5'd9;
      7'b1110111: code = 5'd10;
      7'b0011111: code = 5'd11;
      7'b1001110: code = 5'd12;
      7'b0111101: code = 5'd13;
      7'b1001111: code = 5'd14;
      7'b1000111: code = 5'd15;
      7'b0000000: code = CODE_BLANK;
      default:    code = CODE_BAD;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) dig_nxt[i] = dig_q[i];
    if (commit) dig_nxt[sel_in] = code;
  end

  assign seen_set   = seen_q | (commit ? (4'b0001 << sel_in) : 4'b0000);
  assign frame_done = commit && (seen_set == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    drop      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (frame_done) begin
          load      = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (frame_done) begin
          load = frame_ready;
          drop = !frame_ready;
        end else if (frame_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 9'd0;
      cnt_q      <= 8'd0;
      seen_q     <= 4'b0000;
      frame_data <= 20'd0;
      decode_err <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= CODE_BLANK;
    end else begin
      last_q <= sample;
      cnt_q  <= cnt_nxt;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_nxt[i];
      // A completed frame clears seen whether it was offered or dropped.
      if (frame_done)  seen_q <= 4'b0000;
      else if (commit) seen_q <= seen_set;
      if (load) frame_data <= {dig_nxt[3], dig_nxt[2], dig_nxt[1], dig_nxt[0]};
      if (commit && (code == CODE_BAD)) decode_err <= 1'b1;
      else if (err_clr)                 decode_err <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

  assign frame_valid = (state_q == OFFER);
  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];

endmodule

`default_nettype wire

// File: tb/tb_seg7_mux_capture.sv
// Self-checking bench for seg7_mux_capture: decode table vectors, frame scoreboard,
// overflow, same-edge handshake and asynchronous reset sequences.
`default_nettype none

module tb_seg7_mux_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  seg_in;
  logic [1:0]  sel_in;
  logic        err_clr;
  logic        frame_ready;
  logic [4:0]  dig0, dig1, dig2, dig3;
  logic [19:0] frame_data;
  logic        frame_valid, decode_err, overflow;

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q [$];

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101, P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011, P5 = 7'b1011011, P6 = 7'b1011111, P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111, P9 = 7'b1111011, PA = 7'b1110111, PB = 7'b0011111;
  localparam logic [6:0] PC = 7'b1001110, PD = 7'b0111101, PE = 7'b1001111, PF = 7'b1000111;
  localparam logic [6:0] PBLANK = 7'b0000000, PBAD = 7'b0000001;

  typedef struct {
    logic [6:0] pat;
    logic [1:0] sel;
    logic [4:0] code;
    logic       err;
  } vec_t;

  vec_t vecs [18];

  seg7_mux_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sel_in(sel_in),
    .err_clr(err_clr), .frame_ready(frame_ready),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .decode_err(decode_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] pat, input logic [1:0] sel, input int n);
    seg_in = {pat, 2'b00};
    sel_in = sel;
    repeat (n) tick();
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  function automatic logic [4:0] dig_of(input logic [1:0] s);
    case (s)
      2'd0:    return dig0;
      2'd1:    return dig1;
      2'd2:    return dig2;
      default: return dig3;
    endcase
  endfunction

  // Accepted frames are popped on the negedge before the accepting edge.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL handshake_unexpected: got frame 0x%0h expected no frame", frame_data);
      end else begin
        chk("handshake_frame", 32'(frame_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vecs[0]  = '{P0, 2'd1, 5'd0,  1'b0};
    vecs[1]  = '{P1, 2'd1, 5'd1,  1'b0};
    vecs[2]  = '{P2, 2'd1, 5'd2,  1'b0};
    vecs[3]  = '{P3, 2'd1, 5'd3,  1'b0};
    vecs[4]  = '{P4, 2'd1, 5'd4,  1'b0};
    vecs[5]  = '{P5, 2'd1, 5'd5,  1'b0};
    vecs[6]  = '{P6, 2'd1, 5'd6,  1'b0};
    vecs[7]  = '{P7, 2'd1, 5'd7,  1'b0};
    vecs[8]  = '{P8, 2'd1, 5'd8,  1'b0};
    vecs[9]  = '{P9, 2'd1, 5'd9,  1'b0};
    vecs[10] = '{PA, 2'd1, 5'd10, 1'b0};
    vecs[11] = '{PB, 2'd1, 5'd11, 1'b0};
    vecs[12] = '{PC, 2'd1, 5'd12, 1'b0};
    vecs[13] = '{PD, 2'd1, 5'd13, 1'b0};
    vecs[14] = '{PE, 2'd1, 5'd14, 1'b0};
    vecs[15] = '{PF, 2'd1, 5'd15, 1'b0};
    vecs[16] = '{PBAD,   2'd2, 5'd31, 1'b1};
    vecs[17] = '{PBLANK, 2'd2, 5'd16, 1'b1};

    rst_n = 1'b0;
    err_clr = 1'b0;
    frame_ready = 1'b0;
    seg_in = {P2, 2'b00};
    sel_in = 2'd0;
    #12;
    chk("reset_dig0", 32'(dig0), 32'd16);
    chk("reset_dig3", 32'(dig3), 32'd16);
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_data", 32'(frame_data), 32'd0);
    rst_n = 1'b1;

    // First frame 2,3,4,A held with ready low.
    put(P2, 2'd0, 4);
    chk("commit_dig0", 32'(dig0), 32'd2);
    put(P3, 2'd1, 4);
    put(P4, 2'd2, 4);
    chk("no_frame_yet", 32'(frame_valid), 32'd0);
    exp_q.push_back({5'd10, 5'd4, 5'd3, 5'd2});
    put(PA, 2'd3, 4);
    chk("frame1_valid", 32'(frame_valid), 32'd1);
    chk("frame1_data", 32'(frame_data), 32'({5'd10, 5'd4, 5'd3, 5'd2}));
    repeat (3) tick();
    chk("frame1_held_valid", 32'(frame_valid), 32'd1);
    chk("frame1_held_data", 32'(frame_data), 32'({5'd10, 5'd4, 5'd3, 5'd2}));
    pulse_ready();
    chk("frame1_released", 32'(frame_valid), 32'd0);

    // Second frame completes while the first is still pending: dropped.
    exp_q.push_back({5'd8, 5'd7, 5'd6, 5'd5});
    put(P5, 2'd0, 4); put(P6, 2'd1, 4); put(P7, 2'd2, 4); put(P8, 2'd3, 4);
    chk("frame2_valid", 32'(frame_valid), 32'd1);
    chk("no_overflow_yet", 32'(overflow), 32'd0);
    put(P9, 2'd0, 4); put(P0, 2'd1, 4); put(P1, 2'd2, 4); put(PE, 2'd3, 4);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_data_kept", 32'(frame_data), 32'({5'd8, 5'd7, 5'd6, 5'd5}));
    chk("overflow_dig3", 32'(dig3), 32'd14);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'd0);
    pulse_ready();
    chk("frame2_released", 32'(frame_valid), 32'd0);

    // Ready coincides with the commit that completes the next frame.
    exp_q.push_back({5'd15, 5'd13, 5'd12, 5'd11});
    put(PB, 2'd0, 4); put(PC, 2'd1, 4); put(PD, 2'd2, 4); put(PF, 2'd3, 4);
    chk("frame3_valid", 32'(frame_valid), 32'd1);
    exp_q.push_back({5'd4, 5'd3, 5'd2, 5'd1});
    put(P1, 2'd0, 4); put(P2, 2'd1, 4); put(P3, 2'd2, 4);
    put(P4, 2'd3, 3);
    pulse_ready();
    chk("same_edge_valid", 32'(frame_valid), 32'd1);
    chk("same_edge_data", 32'(frame_data), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
    chk("same_edge_no_overflow", 32'(overflow), 32'd0);
    pulse_ready();
    chk("frame4_released", 32'(frame_valid), 32'd0);

    // A run one edge short of STABLE_CYCLES must not commit.
    put(P1, 2'd1, 3);
    put(P7, 2'd1, 1);
    chk("short_run_dig1", 32'(dig1), 32'd2);
    repeat (3) tick();
    chk("full_run_dig1", 32'(dig1), 32'd7);

    for (int i = 0; i < 18; i++) begin
      put(vecs[i].pat, vecs[i].sel, 4);
      chk($sformatf("decode_%0d", i), 32'(dig_of(vecs[i].sel)), 32'(vecs[i].code));
      chk($sformatf("decode_err_%0d", i), 32'(decode_err), 32'(vecs[i].err));
    end

    // Complete a frame from positions 1,2 left by the table, then reset mid-offer.
    put(P9, 2'd0, 4);
    put(PC, 2'd3, 4);
    chk("frame5_valid", 32'(frame_valid), 32'd1);
    chk("frame5_data", 32'(frame_data), 32'({5'd12, 5'd16, 5'd15, 5'd9}));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(frame_valid), 32'd0);
    chk("async_dig1", 32'(dig1), 32'd16);
    chk("async_dig3", 32'(dig3), 32'd16);
    chk("async_decode_err", 32'(decode_err), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    chk("async_data", 32'(frame_data), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_mux_capture.md
Name: seg7_mux_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment display controller.
- Observes one time-multiplexed segment bus plus its digit select and qualifies each pattern by stability.
- Decodes each stable pattern back to a 5-bit digit code and keeps one register per digit position.
- Assembles complete 4-digit frames and offers them downstream on a valid/ready handshake; used for display loopback checking and panel readback.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a commit. Legal range 1..255.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- seg_in, input, 9: segment pattern. Bits [8:2] are segments a..g; bits [1:0] are ignored.
- sel_in, input, 2: digit position associated with seg_in.
- err_clr, input, 1: synchronous clear of decode_err and overflow.
- frame_ready, input, 1: downstream accepts the frame.
- dig0, dig1, dig2, dig3, output, 5 each: last committed code per position.
- frame_data, output, 20: {dig3, dig2, dig1, dig0} snapshot.
- frame_valid, output, 1: frame_data is offered.
- decode_err, output, 1: sticky; an unrecognised pattern was committed.
- overflow, output, 1: sticky; a completed frame was dropped.

Behaviour:
- Reset (async assert, sync release):
  - dig0..3 = 5'd16.
  - frame_data = 0, frame_valid = 0, decode_err = 0, overflow = 0.
  - seen = 4'b0000, stability counter = 0, last sample = 0, FSM = COLLECT.
  - Asserting rst_n mid-frame or mid-offer discards everything immediately.
- Stability qualifier (every edge):
  - The compared sample is {seg_in[8:2], sel_in}.
  - Sample equals last: cnt <= min(cnt+1, STABLE_CYCLES). Sample differs: cnt <= 1.
  - last <= sample on every edge.
  - Commit on the edge where cnt becomes STABLE_CYCLES from a lower value. Exactly one commit per stable run.
  - Latency: a value first present at edge N commits at edge N+STABLE_CYCLES-1. The dig output is visible after that edge.
  - STABLE_CYCLES=1: commit whenever the sample differs from last, or on the first edge after reset.
  - The post-reset all-zero input is a legitimate stable sample and commits blank to dig0.
- Decode table (seg_in[8:2] -> code):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1111011=9, 1110111=10, 0011111=11
  - 1001110=12, 0111101=13, 1001111=14, 1000111=15
  - 0000000=16 (blank)
  - Any other pattern = 31, and decode_err is set on the commit edge.
- Commit:
  - dig[sel] <= code and seen[sel] <= 1.
  - Recommitting a position already in seen overwrites dig; seen is unchanged.
- Frame FSM:
  - COLLECT:
    - If a commit makes seen == 4'b1111, then frame_data <= concatenation including the just-committed code, frame_valid <= 1, seen <= 0, go to OFFER.
  - OFFER:
    - frame_valid = 1; frame_data held stable.
    - Collection continues in parallel.
    - frame_ready=1 with no frame completion: frame_valid <= 0, go to COLLECT.
    - frame_ready=1 with a frame completion on the same edge: load the new frame, frame_valid stays 1, stay in OFFER.
    - frame_ready=0 with a frame completion: frame dropped, seen <= 0, overflow <= 1, frame_data unchanged.
- Sticky flags:
  - err_clr=1 clears decode_err and overflow.
  - If a set condition occurs on the same edge as err_clr, the set wins.
- Width rules:
  - 5-bit codes throughout.
  - frame_data digit order: dig0 at [4:0], dig3 at [19:15].

Test Plan:
- Assert rst_n low mid-OFFER -> same instant: frame_valid=0, dig0..3=16, overflow=0, decode_err=0.
- seg_in=9'b011000000, sel_in=1 for 4 edges -> dig1=1 after the 4th edge. Held only 3 edges then changed -> dig1 unchanged.
- Patterns for 2, 3, 4, A on sel 0..3, 4 edges each, frame_ready=0 -> frame_valid=1 after the 16th edge, frame_data={5'd10,5'd4,5'd3,5'd2}, held. One-cycle frame_ready -> frame_valid=0 next edge.
- Second full frame while frame_ready=0 -> overflow=1, frame_data still the first frame. err_clr pulse -> overflow=0.
- seg_in=9'b000000100 on sel 2 -> dig2=31, decode_err=1. Then seg_in=0 on sel 2 -> dig2=16, decode_err stays 1.
- frame_ready=1 on the same edge as the 4th commit of a new frame -> frame_valid stays 1 and frame_data updates to the new digits.
